// File: rtl/sobel_stream_ctrl_if.sv
// Stream bundle for sobel_stream_ctrl.
// Pixel input side: s_* (valid/ready).
// Magnitude output side: m_* (valid/ready).
// Frame control: start, busy, frame_done.
// Handshake rule on both sides: a transfer happens on a rising clock edge where
// valid && ready are both high. Valid never depends on ready combinationally,
// and the payload is held stable while valid is high and ready is low.
interface sobel_stream_ctrl_if;
    logic       start;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_pixel;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_magnitude;
    logic       m_last;
    logic       busy;
    logic       frame_done;

    // Pixel source / edge sink side.
    modport master (
        output start, s_valid, s_pixel, m_ready,
        input  s_ready, m_valid, m_magnitude, m_last, busy, frame_done
    );

    // Sequencer side.
    modport slave (
        input  start, s_valid, s_pixel, m_ready,
        output s_ready, m_valid, m_magnitude, m_last, busy, frame_done
    );
endinterface

// File: rtl/sobel_stream_ctrl.sv
// Streaming 3x3 Sobel sequencer.
// Two line buffers plus a two-column window feed a combinational kernel.
// One registered magnitude is produced for every interior pixel.

// Combinational Sobel datapath: |gx| + |gy|, clamped to 255.
module sobel_kernel (
    input  logic [7:0] i_pixel_00,
    input  logic [7:0] i_pixel_01,
    input  logic [7:0] i_pixel_02,
    input  logic [7:0] i_pixel_10,
    input  logic [7:0] i_pixel_12,
    input  logic [7:0] i_pixel_20,
    input  logic [7:0] i_pixel_21,
    input  logic [7:0] i_pixel_22,
    output logic [7:0] o_magnitude
);
    // Each weighted sum is at most 1020, so 12 bits hold the sums and the
    // two's-complement differences (+-1020) without overflow.
    logic [11:0] w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
    logic [11:0] w_gx, w_gy, w_ax, w_ay, w_sum;

    assign w_gx_pos = {4'd0, i_pixel_02} + {3'd0, i_pixel_12, 1'b0} + {4'd0, i_pixel_22};
    assign w_gx_neg = {4'd0, i_pixel_00} + {3'd0, i_pixel_10, 1'b0} + {4'd0, i_pixel_20};
    assign w_gy_pos = {4'd0, i_pixel_00} + {3'd0, i_pixel_01, 1'b0} + {4'd0, i_pixel_02};
    assign w_gy_neg = {4'd0, i_pixel_20} + {3'd0, i_pixel_21, 1'b0} + {4'd0, i_pixel_22};
    assign w_gx     = w_gx_pos - w_gx_neg;
    assign w_gy     = w_gy_pos - w_gy_neg;
    assign w_ax     = w_gx[11] ? (12'd0 - w_gx) : w_gx;
    assign w_ay     = w_gy[11] ? (12'd0 - w_gy) : w_gy;
    // Sum of magnitudes is at most 2040 and fits in 12 bits unsigned.
    assign w_sum       = w_ax + w_ay;
    assign o_magnitude = (w_sum > 12'd255) ? 8'hFF : w_sum[7:0];
endmodule

module sobel_stream_ctrl #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sobel_stream_ctrl_if.slave   bus,
    output logic [1:0]           o_state
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [7:0]  r_lb0 [IMG_W];
    logic [7:0]  r_lb1 [IMG_W];
    // Window columns 1 and 2 (column 0 drops out on every shift).
    logic [7:0]  r_w1_top, r_w1_mid, r_w1_bot;
    logic [7:0]  r_w2_top, r_w2_mid, r_w2_bot;
    logic [7:0]  r_m_mag;
    logic        r_m_valid, r_m_last, r_busy, r_frame_done;

    logic        w_s_ready, w_accept, w_m_xfer, w_eol, w_eof, w_qualify;
    logic [7:0]  w_new_top, w_new_mid, w_kernel_mag;

    assign w_s_ready = (r_state == ST_RUN) && (!r_m_valid || bus.m_ready);
    assign w_accept  = bus.s_valid && w_s_ready;
    assign w_m_xfer  = r_m_valid && bus.m_ready;
    assign w_eol     = (r_col == CW'(IMG_W - 1));
    assign w_eof     = w_eol && (r_row == RW'(IMG_H - 1));
    // Column >= 2 also keeps stale window data from the previous line out.
    assign w_qualify = w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_new_top = r_lb0[r_col];
    assign w_new_mid = r_lb1[r_col];

    sobel_kernel u_kernel (
        .i_pixel_00  (r_w1_top),
        .i_pixel_01  (r_w2_top),
        .i_pixel_02  (w_new_top),
        .i_pixel_10  (r_w1_mid),
        .i_pixel_12  (w_new_mid),
        .i_pixel_20  (r_w1_bot),
        .i_pixel_21  (r_w2_bot),
        .i_pixel_22  (bus.s_pixel),
        .o_magnitude (w_kernel_mag)
    );

    // Frame sequencing: arm on start, drain after the last pixel, idle after m_last.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (bus.start) w_state_next = ST_RUN;
            ST_RUN:   if (w_accept && w_eof) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_m_xfer && r_m_last) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // State register plus registered busy and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_busy       <= (w_state_next != ST_IDLE);
            r_frame_done <= (r_state == ST_DRAIN) && w_m_xfer && r_m_last;
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (r_state == ST_IDLE && bus.start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_eol) begin
                r_col <= '0;
                r_row <= w_eof ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Line buffers roll one row down at the accepted column; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb0[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= bus.s_pixel;
        end
    end

    // Window shifts left and takes the freshly assembled column on the right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w1_top <= '0; r_w1_mid <= '0; r_w1_bot <= '0;
            r_w2_top <= '0; r_w2_mid <= '0; r_w2_bot <= '0;
        end else if (w_accept) begin
            r_w1_top <= r_w2_top; r_w1_mid <= r_w2_mid; r_w1_bot <= r_w2_bot;
            r_w2_top <= w_new_top; r_w2_mid <= w_new_mid; r_w2_bot <= bus.s_pixel;
        end
    end

    // Output register: reload on an interior accept, otherwise empty on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_mag   <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else if (w_qualify) begin
            r_m_mag   <= w_kernel_mag;
            r_m_valid <= 1'b1;
            r_m_last  <= w_eof;
        end else if (w_m_xfer) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end
    end

    assign bus.s_ready     = w_s_ready;
    assign bus.m_valid     = r_m_valid;
    assign bus.m_magnitude = r_m_mag;
    assign bus.m_last      = r_m_last;
    assign bus.busy        = r_busy;
    assign bus.frame_done  = r_frame_done;
    assign o_state         = r_state;
endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Bench for sobel_stream_ctrl: an 8x6 instance for frame scenarios and a
// 3x3 instance for the minimum frame.
module tb_sobel_stream_ctrl;
    localparam int W = 8;
    localparam int H = 6;
    localparam int NOUT = (W - 2) * (H - 2);

    logic clk;
    logic rst_n;
    logic [1:0] dut_state, dut3_state;

    sobel_stream_ctrl_if bus ();
    sobel_stream_ctrl_if bus3 ();

    sobel_stream_ctrl #(.IMG_W(W), .IMG_H(H)) u_dut (
        .clk (clk), .rst_n (rst_n), .bus (bus), .o_state (dut_state)
    );
    sobel_stream_ctrl #(.IMG_W(3), .IMG_H(3)) u_dut3 (
        .clk (clk), .rst_n (rst_n), .bus (bus3), .o_state (dut3_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // results collected by run_frame
    logic [7:0] got_mag_q[$];
    logic       got_last_q[$];
    logic [7:0] exp_q[$];
    int fd_count, stall_viol, stable_viol, src_cycles;
    bit timed_out;

    function automatic logic [7:0] pix(input int pat, input int r, input int c);
        case (pat)
            0:       return 8'd100;
            1:       return (c >= 4) ? 8'd200 : 8'd0;
            2:       return 8'(10 * c);
            3:       return 8'(10 * r);
            default: return 8'd0;
        endcase
    endfunction

    // Hand-derived answers per centre column for each pattern.
    function automatic logic [7:0] exp_mag(input int pat, input int cc);
        case (pat)
            1:       return (cc == 3 || cc == 4) ? 8'd255 : 8'd0;
            2, 3:    return 8'd80;
            default: return 8'd0;
        endcase
    endfunction

    function automatic void build_exp(input int pat);
        exp_q.delete();
        for (int k = 0; k < NOUT; k++) exp_q.push_back(exp_mag(pat, 1 + k % (W - 2)));
    endfunction

    // driver: one full frame on the 8x6 instance, optional random stalls
    task automatic run_frame(input int pat, input bit stall);
        got_mag_q.delete();
        got_last_q.delete();
        fd_count = 0; stall_viol = 0; stable_viol = 0; src_cycles = 0; timed_out = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        fork
            begin : src
                int idx = 0;
                int cyc = 0;
                while (idx < W * H && cyc < 4000) begin
                    bus.s_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
                    bus.s_pixel = pix(pat, idx / W, idx % W);
                    @(negedge clk);
                    if (bus.s_valid && bus.s_ready) idx++;
                    cyc++;
                    @(posedge clk); #1;
                end
                bus.s_valid = 1'b0;
                src_cycles = cyc;
                if (idx < W * H) timed_out = 1;
            end
            begin : snk
                int cyc = 0;
                bit done = 0;
                bit prev_stall = 0;
                logic [7:0] prev_mag = '0;
                logic prev_last = 1'b0;
                while (!done && cyc < 4000) begin
                    bus.m_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
                    @(negedge clk);
                    if (bus.frame_done) fd_count++;
                    if (prev_stall && (!bus.m_valid || bus.m_magnitude !== prev_mag ||
                                       bus.m_last !== prev_last)) stable_viol++;
                    if (bus.m_valid && !bus.m_ready && bus.s_ready) stall_viol++;
                    if (bus.m_valid && bus.m_ready) begin
                        got_mag_q.push_back(bus.m_magnitude);
                        got_last_q.push_back(bus.m_last);
                        if (bus.m_last) done = 1;
                    end
                    prev_stall = bus.m_valid && !bus.m_ready;
                    prev_mag   = bus.m_magnitude;
                    prev_last  = bus.m_last;
                    cyc++;
                    @(posedge clk); #1;
                end
                bus.m_ready = 1'b1;
                if (!done) timed_out = 1;
                repeat (3) begin
                    @(negedge clk);
                    if (bus.frame_done) fd_count++;
                    @(posedge clk); #1;
                end
            end
        join
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
        n_tests++; if (bus.m_magnitude !== 8'd0) begin n_fail++; $display("FAIL reset_mag: got %0d expected 0", bus.m_magnitude); end
        n_tests++; if (bus.m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %b expected 0", bus.m_last); end
        n_tests++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 0", bus.s_ready); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_tests++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
        n_tests++; if (dut_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dut_state); end
        n_tests++; if (bus3.m_valid !== 1'b0 || bus3.busy !== 1'b0) begin n_fail++; $display("FAIL reset_dut3: got valid=%b busy=%b expected 0 0", bus3.m_valid, bus3.busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_flat;
        run_frame(0, 1'b0);
        build_exp(0);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL flat_timeout: got timeout expected completion"); end
        n_tests++; if (got_mag_q.size() != NOUT) begin n_fail++; $display("FAIL flat_count: got %0d expected %0d", got_mag_q.size(), NOUT); end
        for (int k = 0; k < got_mag_q.size() && k < NOUT; k++) begin
            n_tests++; if (got_mag_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL flat_mag[%0d]: got %0d expected %0d", k, got_mag_q[k], exp_q[k]); end
            n_tests++; if (got_last_q[k] !== (k == NOUT - 1)) begin n_fail++; $display("FAIL flat_last[%0d]: got %b expected %b", k, got_last_q[k], k == NOUT - 1); end
        end
        n_tests++; if (fd_count != 1) begin n_fail++; $display("FAIL flat_frame_done: got %0d pulses expected 1", fd_count); end
        n_tests++; if (src_cycles != W * H) begin n_fail++; $display("FAIL flat_throughput: got %0d cycles expected %0d", src_cycles, W * H); end
        n_tests++; if (dut_state !== 2'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL flat_idle: got state=%0d busy=%b expected 0 0", dut_state, bus.busy); end
    endtask

    task automatic test_vertical_edge;
        run_frame(1, 1'b0);
        build_exp(1);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL vedge_timeout: got timeout expected completion"); end
        n_tests++; if (got_mag_q.size() != NOUT) begin n_fail++; $display("FAIL vedge_count: got %0d expected %0d", got_mag_q.size(), NOUT); end
        for (int k = 0; k < got_mag_q.size() && k < NOUT; k++) begin
            n_tests++; if (got_mag_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL vedge_mag[%0d]: got %0d expected %0d", k, got_mag_q[k], exp_q[k]); end
        end
        n_tests++; if (fd_count != 1) begin n_fail++; $display("FAIL vedge_frame_done: got %0d pulses expected 1", fd_count); end
    endtask

    task automatic test_ramps;
        for (int pat = 2; pat <= 3; pat++) begin
            run_frame(pat, 1'b0);
            build_exp(pat);
            n_tests++; if (got_mag_q.size() != NOUT || timed_out) begin n_fail++; $display("FAIL ramp%0d_count: got %0d expected %0d", pat, got_mag_q.size(), NOUT); end
            for (int k = 0; k < got_mag_q.size() && k < NOUT; k++) begin
                n_tests++; if (got_mag_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL ramp%0d_mag[%0d]: got %0d expected %0d", pat, k, got_mag_q[k], exp_q[k]); end
            end
        end
    endtask

    task automatic test_backpressure;
        run_frame(1, 1'b1);
        build_exp(1);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL bp_timeout: got timeout expected completion"); end
        n_tests++; if (got_mag_q.size() != NOUT) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", got_mag_q.size(), NOUT); end
        for (int k = 0; k < got_mag_q.size() && k < NOUT; k++) begin
            n_tests++; if (got_mag_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL bp_mag[%0d]: got %0d expected %0d", k, got_mag_q[k], exp_q[k]); end
            n_tests++; if (got_last_q[k] !== (k == NOUT - 1)) begin n_fail++; $display("FAIL bp_last[%0d]: got %b expected %b", k, got_last_q[k], k == NOUT - 1); end
        end
        n_tests++; if (stall_viol != 0) begin n_fail++; $display("FAIL bp_s_ready_stall: got %0d cycles with s_ready high expected 0", stall_viol); end
        n_tests++; if (stable_viol != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable stalled cycles expected 0", stable_viol); end
        n_tests++; if (fd_count != 1) begin n_fail++; $display("FAIL bp_frame_done: got %0d pulses expected 1", fd_count); end
    endtask

    // 3x3 frame: gx = 240-160 = 80, gy = 80-320 = -240, sum 320 -> 255.
    task automatic test_min_frame;
        logic [7:0] tab [9];
        int cnt = 0;
        int fd = 0;
        logic [7:0] mag = '0;
        logic last = 1'b0;
        tab = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
        bus3.m_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            bus3.start   = (i == 0) || (i == 5);
            bus3.s_valid = (i >= 1 && i <= 9);
            bus3.s_pixel = (i >= 1 && i <= 9) ? tab[i - 1] : 8'd0;
            @(negedge clk);
            if (i >= 1 && i <= 9) begin
                n_tests++; if (bus3.s_ready !== 1'b1) begin n_fail++; $display("FAIL min_accept[%0d]: got s_ready=%b expected 1", i - 1, bus3.s_ready); end
            end
            if (i == 6) begin
                n_tests++; if (dut3_state !== 2'd1) begin n_fail++; $display("FAIL min_start_ignored: got state=%0d expected 1", dut3_state); end
            end
            if (bus3.m_valid && bus3.m_ready) begin
                cnt++;
                mag  = bus3.m_magnitude;
                last = bus3.m_last;
            end
            if (bus3.frame_done) fd++;
        end
        bus3.start = 1'b0;
        bus3.s_valid = 1'b0;
        n_tests++; if (cnt != 1) begin n_fail++; $display("FAIL min_count: got %0d expected 1", cnt); end
        n_tests++; if (mag !== 8'd255) begin n_fail++; $display("FAIL min_mag: got %0d expected 255", mag); end
        n_tests++; if (last !== 1'b1) begin n_fail++; $display("FAIL min_last: got %b expected 1", last); end
        n_tests++; if (fd != 1) begin n_fail++; $display("FAIL min_frame_done: got %0d pulses expected 1", fd); end
        n_tests++; if (dut3_state !== 2'd0) begin n_fail++; $display("FAIL min_idle: got state=%0d expected 0", dut3_state); end
    endtask

    task automatic test_mid_frame_reset;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.m_ready = 1'b1;
        for (int idx = 0; idx < 20; idx++) begin
            bus.s_valid = 1'b1;
            bus.s_pixel = pix(1, idx / W, idx % W);
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.m_valid !== 1'b0 || bus.m_last !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got valid=%b last=%b expected 0 0", bus.m_valid, bus.m_last); end
        n_tests++; if (bus.m_magnitude !== 8'd0) begin n_fail++; $display("FAIL rst_mid_mag: got %0d expected 0", bus.m_magnitude); end
        n_tests++; if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got busy=%b done=%b expected 0 0", bus.busy, bus.frame_done); end
        n_tests++; if (dut_state !== 2'd0 || bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state: got state=%0d s_ready=%b expected 0 0", dut_state, bus.s_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        run_frame(0, 1'b0);
        build_exp(0);
        n_tests++; if (got_mag_q.size() != NOUT || timed_out) begin n_fail++; $display("FAIL rst_clean_count: got %0d expected %0d", got_mag_q.size(), NOUT); end
        for (int k = 0; k < got_mag_q.size() && k < NOUT; k++) begin
            n_tests++; if (got_mag_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rst_clean_mag[%0d]: got %0d expected %0d", k, got_mag_q[k], exp_q[k]); end
        end
        n_tests++; if (fd_count != 1) begin n_fail++; $display("FAIL rst_clean_frame_done: got %0d pulses expected 1", fd_count); end
    endtask

    initial begin
        bus.start = 1'b0;  bus.s_valid = 1'b0;  bus.s_pixel = '0;  bus.m_ready = 1'b1;
        bus3.start = 1'b0; bus3.s_valid = 1'b0; bus3.s_pixel = '0; bus3.m_ready = 1'b1;
        rst_n = 1'b0;
        test_reset;
        test_flat;
        test_vertical_edge;
        test_ramps;
        test_backpressure;
        test_min_frame;
        test_mid_frame_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sobel_stream_ctrl.md
# sobel_stream_ctrl

Streaming sequencer for the combinational `sobel_kernel` datapath. It accepts a raster-order 8-bit pixel stream, keeps two line buffers and a 3x3 window, and drives one `sobel_kernel` instance. It emits one registered edge magnitude per interior pixel through a valid/ready output. It sits between the pixel source (camera/DMA front end) and the edge-image sink, and owns frame start/end sequencing.

## Interface
- `IMG_W`, 64: pixels per line. Minimum 3.
- `IMG_H`, 48: lines per frame. Minimum 3.
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that arms a frame. Honoured only in IDLE.
- `s_valid` input 1: input pixel valid.
- `s_ready` output 1: input pixel accepted when `s_valid && s_ready`.
- `s_pixel` input 8: input pixel, raster order, row 0 first.
- `m_valid` output 1: output magnitude valid.
- `m_ready` input 1: sink ready; output transfer when `m_valid && m_ready`.
- `m_magnitude` output 8: clamped edge magnitude.
- `m_last` output 1: qualifies the final output of a frame.
- `busy` output 1: high in RUN and DRAIN.
- `frame_done` output 1: one-cycle pulse after the last output transfers.

## Operation
- Reset values: state IDLE; `s_ready`, `m_valid`, `m_last`, `busy`, `frame_done` all 0; `m_magnitude` 0; row/column counters 0. Line buffer contents are don't-care.
- FSM states and transitions:
  - IDLE → RUN on `start`. Clears the row and column counters.
  - RUN → DRAIN on acceptance of pixel (IMG_H-1, IMG_W-1).
  - DRAIN → IDLE on transfer of the `m_last` output.
  - `start` in RUN or DRAIN is ignored.
- Counters: `col` runs 0..IMG_W-1. `row` runs 0..IMG_H-1. Both advance only on accept. `col` wraps to 0 and `row` increments at end of line.
- Line buffers:
  - `lb0` holds row r-2 and `lb1` holds row r-1, each IMG_W x 8, indexed by `col`, read combinationally.
  - On accept at column c: new window column is {top `lb0[c]`, mid `lb1[c]`, bottom `s_pixel`}. Then `lb0[c]` ← `lb1[c]` and `lb1[c]` ← `s_pixel`.
- Window:
  - Three columns of three pixels. On accept, shift left by one and insert the new column at the right.
  - Kernel inputs `pixel_00..pixel_22` are {window col 1, window col 2, new column}, with `pixel_r0` leftmost and `pixel_0c` the top row.
  - This is combinational at accept time.
- Output generation:
  - An accept at (r, c) with r ≥ 2 and c ≥ 2 loads `m_magnitude` ← kernel `magnitude`, sets `m_valid` = 1, and sets `m_last` = (r == IMG_H-1 && c == IMG_W-1).
  - That output is the magnitude for centre pixel (r-1, c-1).
  - Border pixels produce no output. Output count per frame is exactly (IMG_W-2)*(IMG_H-2).
- Arithmetic (inside `sobel_kernel`):
  - gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20).
  - gy = (p00 + 2·p01 + p02) − (p20 + 2·p21 + p22).
  - Both are 12-bit signed, range ±1020.
  - magnitude = min(|gx| + |gy|, 255).
- Window content carried across a line boundary never reaches the output, because the c ≥ 2 rule excludes it.

## Timing
- `s_ready` = (state == RUN) && (!`m_valid` || `m_ready`). It is combinational from state and the output register.
  - A stalled sink therefore stalls the input with no pixel loss.
  - No skid buffer is used.
- Latency: an output becomes visible on `m_valid` the cycle after the qualifying input accept.
- Sustained throughput: 1 pixel/cycle when `s_valid` and `m_ready` are held high.
- Output register update on a clock edge:
  - If an output transfers and a new qualifying pixel is accepted in the same cycle, the register reloads and `m_valid` stays 1.
  - If an output transfers with no new qualifying accept, `m_valid` goes to 0.
- `m_magnitude` and `m_last` hold stable while `m_valid && !m_ready`.
- DRAIN: `s_ready` = 0. When the `m_last` output transfers, the FSM moves to IDLE and `frame_done` pulses high for the following cycle.
- `busy` is registered and reflects the current state (RUN or DRAIN).
- `rst_n` asserted mid-frame:
  - Immediately returns to IDLE and drops all outputs to their reset values.
  - The partial frame is discarded; no `frame_done`.
  - The next `start` begins a clean frame.

## Test plan
- Flat frame, IMG_W=8, IMG_H=6, every pixel 100, sink always ready → 24 outputs, all 0. `m_last` only on the 24th. One `frame_done` pulse. Throughput 1/cycle.
- Vertical edge, 8x6, pixel = 200 when col ≥ 4 else 0 → per output row: centre cols 1,2 = 0; cols 3,4 = 255 (gx = 800, clamped); cols 5,6 = 0.
- Horizontal ramp, pixel = 10·col → every output 80 (gx = 80, gy = 0). Vertical ramp, pixel = 10·row → every output 80.
- Backpressure, random `s_valid` and `m_ready` at 50% → output sequence identical to the unstalled run. `s_ready` is low in every cycle where `m_valid && !m_ready`. `m_magnitude` is stable while stalled.
- Minimum frame 3x3 with rows {10,20,30},{40,50,60},{70,80,90} → exactly one output, magnitude 255 (gx = 80, gy = −240, sum 320, clamped), with `m_last` = 1. `start` pulsed during RUN is ignored.
- Reset mid-frame after 20 accepts → all outputs 0 and IDLE next cycle. A new `start` plus a flat 8x6 frame yields 24 zeros with no residue from the partial frame.
